// File: rtl/preadder_mt_pkg.sv
// PARAMS_BN254_d0: shared polynomial operand type and pre-adder mode encoding.
package PARAMS_BN254_d0;
    localparam int POLY_N = 4;
    localparam int COEF_W = 16;
    typedef logic [POLY_N-1:0][COEF_W-1:0] redundant_poly_L3;
    typedef enum logic [1:0] {
        PA_BYPASS    = 2'b00,
        PA_SUMDIFF   = 2'b01,
        PA_ACC_PREV  = 2'b10,
        PA_DIFF_PREV = 2'b11
    } preadder_mode_t;
endpackage

// File: rtl/poly_adder_L3_L3.sv
// poly_adder_L3_L3: coefficient-wise add/subtract in redundant form, LATENCY register stages.
module poly_adder_L3_L3
    import PARAMS_BN254_d0::*;
#(
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  redundant_poly_L3 a,
    input  redundant_poly_L3 b,
    input  logic             sub,
    output redundant_poly_L3 s
);
    redundant_poly_L3 r;
    always_comb begin
        r = '0;
        for (int i = 0; i < POLY_N; i++) r[i] = sub ? a[i] - b[i] : a[i] + b[i];
    end
    if (LATENCY == 0) begin : g_comb
        assign s = r;
    end else begin : g_pipe
        redundant_poly_L3 p [LATENCY];
        always_ff @(posedge clk) begin
            p[0] <= r;
            for (int i = 1; i < LATENCY; i++) p[i] <= p[i-1];
        end
        assign s = p[LATENCY-1];
    end
endmodule

// File: rtl/poly_delay_line.sv
// poly_delay_line: enable-gated shift register of polynomials; clr empties it before any same-edge write.
module poly_delay_line
    import PARAMS_BN254_d0::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  redundant_poly_L3 din,
    output redundant_poly_L3 tail
);
    redundant_poly_L3 d [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else if (en || clr) begin
            for (int i = 1; i < DEPTH; i++) d[i] <= clr ? '0 : d[i-1];
            d[0] <= en ? din : '0;
        end
    end
    assign tail = d[DEPTH-1];
endmodule

// File: rtl/preadder_mt.sv
// preadder_mt: multi-thread valid-qualified pre-adder; pairs each beat with its thread's previous sample.
module preadder_mt
    import PARAMS_BN254_d0::*;
#(
    parameter int THREADS     = 4,
    parameter int ADD_LATENCY = 1,
    parameter int TID_W       = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  redundant_poly_L3 X,
    input  redundant_poly_L3 Y,
    input  preadder_mode_t   mode,
    input  logic             flush,
    output logic             out_valid,
    output logic [TID_W-1:0] out_tid,
    output redundant_poly_L3 Z0,
    output redundant_poly_L3 Z1
);
    localparam int SW = TID_W + 3;
    logic [TID_W-1:0] tid, cur_tid, d_tid;
    redundant_poly_L3 tail_x, tail_y, px, py, s_sum, s_dif, s_x, s_y;
    logic use_prev, sub_prev, d_v;
    logic [SW-1:0] side_in, side_out;
    preadder_mode_t d_mode;
    assign cur_tid  = flush ? '0 : tid;
    assign use_prev = mode[1] && !flush;
    assign sub_prev = mode == PA_DIFF_PREV;
    // BYPASS rides the prev adders with a zero operand so every mode shares one latency
    assign px = use_prev ? tail_x : '0;
    assign py = use_prev ? tail_y : '0;
    always_ff @(posedge clk) begin
        if (rst) tid <= '0;
        else if (in_valid) tid <= (cur_tid == TID_W'(THREADS - 1)) ? '0 : cur_tid + 1'b1;
        else if (flush) tid <= '0;
    end
    poly_delay_line #(.DEPTH(THREADS)) u_dx (.clk(clk), .rst(rst), .clr(flush), .en(in_valid), .din(X), .tail(tail_x));
    poly_delay_line #(.DEPTH(THREADS)) u_dy (.clk(clk), .rst(rst), .clr(flush), .en(in_valid), .din(Y), .tail(tail_y));
    poly_adder_L3_L3 #(.LATENCY(ADD_LATENCY)) u_sum (.clk(clk), .a(X), .b(Y), .sub(1'b0), .s(s_sum));
    poly_adder_L3_L3 #(.LATENCY(ADD_LATENCY)) u_dif (.clk(clk), .a(X), .b(Y), .sub(1'b1), .s(s_dif));
    poly_adder_L3_L3 #(.LATENCY(ADD_LATENCY)) u_px  (.clk(clk), .a(X), .b(px), .sub(sub_prev), .s(s_x));
    poly_adder_L3_L3 #(.LATENCY(ADD_LATENCY)) u_py  (.clk(clk), .a(Y), .b(py), .sub(sub_prev), .s(s_y));
    assign side_in = {in_valid, cur_tid, mode};
    if (ADD_LATENCY == 0) begin : g_side_comb
        assign side_out = side_in;
    end else begin : g_side_pipe
        logic [SW-1:0] sp [ADD_LATENCY];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < ADD_LATENCY; i++) sp[i] <= '0;
            end else begin
                sp[0] <= side_in;
                for (int i = 1; i < ADD_LATENCY; i++) sp[i] <= sp[i-1];
            end
        end
        assign side_out = sp[ADD_LATENCY-1];
    end
    assign d_v    = side_out[SW-1];
    assign d_tid  = side_out[SW-2 -: TID_W];
    assign d_mode = preadder_mode_t'(side_out[1:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_tid   <= '0;
            Z0        <= '0;
            Z1        <= '0;
        end else begin
            out_valid <= d_v;
            if (d_v) begin
                out_tid <= d_tid;
                Z0      <= (d_mode == PA_SUMDIFF) ? s_sum : s_x;
                Z1      <= (d_mode == PA_SUMDIFF) ? s_dif : s_y;
            end
        end
    end
endmodule

// File: tb/tb_preadder_mt.sv
// tb_preadder_mt: directed checks of preadder_mt at ADD_LATENCY 1 (main), 0 and 2 sharing one stimulus.
module tb_preadder_mt;
    import PARAMS_BN254_d0::*;
    localparam int LAT [3] = '{1, 0, 2};
    logic clk = 1'b0;
    logic rst, in_valid, flush;
    redundant_poly_L3 X, Y;
    preadder_mode_t mode;
    logic ov [3];
    logic [1:0] ot [3];
    redundant_poly_L3 z0 [3], z1 [3];
    int vecs = 0;
    int errs = 0;
    always #5 clk = ~clk;
    preadder_mt #(.THREADS(4), .ADD_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .X(X), .Y(Y), .mode(mode), .flush(flush),
        .out_valid(ov[0]), .out_tid(ot[0]), .Z0(z0[0]), .Z1(z1[0]));
    preadder_mt #(.THREADS(4), .ADD_LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .X(X), .Y(Y), .mode(mode), .flush(flush),
        .out_valid(ov[1]), .out_tid(ot[1]), .Z0(z0[1]), .Z1(z1[1]));
    preadder_mt #(.THREADS(4), .ADD_LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .X(X), .Y(Y), .mode(mode), .flush(flush),
        .out_valid(ov[2]), .out_tid(ot[2]), .Z0(z0[2]), .Z1(z1[2]));
    function automatic redundant_poly_L3 mk(input int v);
        redundant_poly_L3 r;
        for (int i = 0; i < POLY_N; i++) r[i] = COEF_W'(v * (i + 1));
        return r;
    endfunction
    task automatic drive(input logic v, input int x, input int y, input preadder_mode_t m, input logic f);
        in_valid = v;
        X        = mk(x);
        Y        = mk(y);
        mode     = m;
        flush    = f;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 5, 3, PA_SUMDIFF, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) begin
                rst = 1'b0;
                drive(1'b0, 0, 0, PA_BYPASS, 1'b0);
            end
            for (int d = 0; d < 3; d++) begin
                vecs++;
                if (ov[d] !== 1'b0 || z0[d] !== '0 || z1[d] !== '0 || ot[d] !== 2'd0) begin
                    errs++;
                    $display("FAIL reset dut%0d c%0d: got v=%b z0=%h z1=%h tid=%0d, expected all zero", d, c, ov[d], z0[d], z1[d], ot[d]);
                end
            end
        end
    endtask
    task automatic test_sumdiff;
        @(negedge clk);
        drive(1'b1, 5, 3, PA_SUMDIFF, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            drive(1'b0, 0, 0, PA_BYPASS, 1'b0);
            for (int d = 0; d < 3; d++) begin
                vecs++;
                if (ov[d] !== (c == LAT[d] + 1)) begin
                    errs++;
                    $display("FAIL sumdiff valid dut%0d c%0d: got %b expected %b", d, c, ov[d], c == LAT[d] + 1);
                end
                if (c == LAT[d] + 1) begin
                    vecs++;
                    if (z0[d] !== mk(8) || z1[d] !== mk(2) || ot[d] !== 2'd0) begin
                        errs++;
                        $display("FAIL sumdiff data dut%0d: got z0=%h z1=%h tid=%0d expected z0=%h z1=%h tid=0", d, z0[d], z1[d], ot[d], mk(8), mk(2));
                    end
                end
            end
        end
    endtask
    task automatic test_acc_prev;
        for (int t = 0; t < 8 + LAT[0] + 2; t++) begin
            int j, e;
            @(negedge clk);
            j = t - LAT[0] - 1;
            vecs++;
            if (ov[0] !== (j >= 0 && j < 8)) begin
                errs++;
                $display("FAIL acc valid t%0d: got %b expected %b", t, ov[0], j >= 0 && j < 8);
            end
            if (j >= 0 && j < 8) begin
                e = (j < 4) ? j + 1 : 2 * (j + 1) - 4;
                vecs++;
                if (z0[0] !== mk(e) || z1[0] !== mk(e) || ot[0] !== 2'(j % 4)) begin
                    errs++;
                    $display("FAIL acc data beat%0d: got z0=%h z1=%h tid=%0d expected z=%h tid=%0d", j, z0[0], z1[0], ot[0], mk(e), j % 4);
                end
            end
            if (t < 8) drive(1'b1, t + 1, t + 1, PA_ACC_PREV, t == 0);
            else drive(1'b0, 0, 0, PA_BYPASS, 1'b0);
        end
    endtask
    task automatic test_valid_gaps;
        redundant_poly_L3 last = mk(12);
        for (int t = 0; t < 3 * 7 + LAT[0] + 3; t++) begin
            int j, e;
            logic ev;
            @(negedge clk);
            j  = t - LAT[0] - 1;
            ev = j >= 0 && j % 3 == 0 && j / 3 < 8;
            vecs++;
            if (ov[0] !== ev) begin
                errs++;
                $display("FAIL gaps valid t%0d: got %b expected %b", t, ov[0], ev);
            end
            if (ev) begin
                e    = (j / 3 < 4) ? j / 3 + 1 : 2 * (j / 3 + 1) - 4;
                last = mk(e);
                vecs++;
                if (z0[0] !== last || z1[0] !== last || ot[0] !== 2'((j / 3) % 4)) begin
                    errs++;
                    $display("FAIL gaps data beat%0d: got z0=%h z1=%h tid=%0d expected z=%h tid=%0d", j / 3, z0[0], z1[0], ot[0], last, (j / 3) % 4);
                end
            end else begin
                vecs++;
                if (z0[0] !== last || z1[0] !== last) begin
                    errs++;
                    $display("FAIL gaps hold t%0d: got z0=%h z1=%h expected %h", t, z0[0], z1[0], last);
                end
            end
            if (t % 3 == 0 && t / 3 < 8) drive(1'b1, t / 3 + 1, t / 3 + 1, PA_ACC_PREV, t == 0);
            else drive(1'b0, 0, 0, PA_BYPASS, 1'b0);
        end
    endtask
    task automatic test_diff_flush;
        int xs [6] = '{10, 7, 1, 2, 3, 9};
        int ys [6] = '{20, 4, 1, 1, 1, 10};
        int e0 [6] = '{5, 7, 1, 2, 3, 2};
        int e1 [6] = '{15, 4, 1, 1, 1, 6};
        int et [6] = '{0, 0, 1, 2, 3, 0};
        for (int t = 0; t < 6 + LAT[0] + 2; t++) begin
            int j;
            @(negedge clk);
            j = t - LAT[0] - 1;
            vecs++;
            if (ov[0] !== (j >= 0 && j < 6)) begin
                errs++;
                $display("FAIL diff valid t%0d: got %b expected %b", t, ov[0], j >= 0 && j < 6);
            end
            if (j >= 0 && j < 6) begin
                vecs++;
                if (z0[0] !== mk(e0[j]) || z1[0] !== mk(e1[j]) || ot[0] !== 2'(et[j])) begin
                    errs++;
                    $display("FAIL diff data beat%0d: got z0=%h z1=%h tid=%0d expected z0=%h z1=%h tid=%0d", j, z0[0], z1[0], ot[0], mk(e0[j]), mk(e1[j]), et[j]);
                end
            end
            if (t < 6) drive(1'b1, xs[t], ys[t], PA_DIFF_PREV, t == 1);
            else drive(1'b0, 0, 0, PA_BYPASS, 1'b0);
        end
    endtask
    task automatic test_back_to_back;
        int xs [8] = '{10, 13, 16, 19, 22, 25, 28, 31};
        int ys [8] = '{2, 3, 4, 5, 6, 7, 8, 9};
        int e0 [8] = '{10, 16, 16, 19, 22, 32, 44, 12};
        int e1 [8] = '{2, 10, 4, 5, 6, 18, 12, 4};
        for (int t = 0; t < 8 + 2 + 2; t++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                int j;
                j = t - LAT[d] - 1;
                vecs++;
                if (ov[d] !== (j >= 0 && j < 8)) begin
                    errs++;
                    $display("FAIL mix valid dut%0d t%0d: got %b expected %b", d, t, ov[d], j >= 0 && j < 8);
                end
                if (j >= 0 && j < 8) begin
                    vecs++;
                    if (z0[d] !== mk(e0[j]) || z1[d] !== mk(e1[j]) || ot[d] !== 2'(j % 4)) begin
                        errs++;
                        $display("FAIL mix data dut%0d beat%0d: got z0=%h z1=%h tid=%0d expected z0=%h z1=%h tid=%0d", d, j, z0[d], z1[d], ot[d], mk(e0[j]), mk(e1[j]), j % 4);
                    end
                end
            end
            if (t < 8) drive(1'b1, xs[t], ys[t], preadder_mode_t'(2'(t % 4)), t == 0);
            else drive(1'b0, 0, 0, PA_BYPASS, 1'b0);
        end
    endtask
    initial begin
        test_reset;
        test_sumdiff;
        test_acc_prev;
        test_valid_gaps;
        test_diff_flush;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
